// File: rtl/bcd_count_ctrl_pkg.sv
// Shared types for the BCD counter run-control block: state encoding, counter width, terminal helper.
// Pure declarations; no latency or flow control of its own.
package bcd_count_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter value that, when enabled once more, lands on target (target 0 means wrap to 0).
    function automatic logic [CNT_W-1:0] term_value(input logic [CNT_W-1:0] target,
                                                    input int modulus);
        return (target == '0) ? CNT_W'(modulus - 1) : target - CNT_W'(1);
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Front-panel controls, counter feedback and counter strobes between panel logic and the counter.
// Level/pulse signals only; no handshake, the controller acts on every sampled cycle.
interface bcd_count_ctrl_if;
    import bcd_count_ctrl_pkg::*;

    logic             Start;
    logic             Stop;
    logic             Pause;
    logic             Step;
    logic             Load;
    logic [CNT_W-1:0] Load_Val;
    logic             Mode;
    logic [CNT_W-1:0] Target;
    logic             Auto_Reload;
    logic [CNT_W-1:0] Cnt_Q;

    logic             Cnt_En;
    logic             Cnt_Clr;
    logic             Cnt_Load;
    logic [CNT_W-1:0] Cnt_D;
    logic             Busy;
    logic             Done;
    logic [1:0]       State;

    modport master (
        output Start, Stop, Pause, Step, Load, Load_Val, Mode, Target, Auto_Reload, Cnt_Q,
        input  Cnt_En, Cnt_Clr, Cnt_Load, Cnt_D, Busy, Done, State
    );

    modport slave (
        input  Start, Stop, Pause, Step, Load, Load_Val, Mode, Target, Auto_Reload, Cnt_Q,
        output Cnt_En, Cnt_Clr, Cnt_Load, Cnt_D, Busy, Done, State
    );

endinterface

// File: rtl/bcd_count_ctrl_tick_prescaler.sv
// Divides the system clock into a tick every DIV_SLOW or DIV_FAST cycles while run is high.
// tick is combinational from the count register; holding run low freezes the count.
module tick_prescaler #(
    parameter int DIV_SLOW = 25_000_000,
    parameter int DIV_FAST = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    input  logic mode,
    output logic tick
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int PW      = $clog2(DIV_MAX) + 1;

    localparam logic [PW-1:0] SLOW_DIV  = PW'(DIV_SLOW);
    localparam logic [PW-1:0] FAST_DIV  = PW'(DIV_FAST);
    localparam logic [PW-1:0] SLOW_LAST = PW'(DIV_SLOW - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(DIV_FAST - 1);

    logic [PW-1:0] pre_cnt;
    logic          mode_cur;
    logic          wrap;

    // Period is latched at each wrap; a newly selected shorter period already overrun wraps at once.
    assign wrap = (pre_cnt == (mode_cur ? FAST_LAST : SLOW_LAST))
               || (pre_cnt >= (mode ? FAST_DIV : SLOW_DIV));
    assign tick = run && wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            mode_cur <= 1'b0;
        end else if (clr) begin
            pre_cnt  <= '0;
            mode_cur <= mode;
        end else if (run) begin
            if (wrap) begin
                pre_cnt  <= '0;
                mode_cur <= mode;
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run-control sequencer for the mod-MODULUS counter: start/stop/pause/step/preset, target detect.
// All outputs registered, one cycle after the sampled input; no backpressure, counter must accept every strobe.
module bcd_count_ctrl
    import bcd_count_ctrl_pkg::*;
#(
    parameter int MODULUS  = 10,
    parameter int DIV_SLOW = 25_000_000,
    parameter int DIV_FAST = 12_500_000
) (
    input  logic          Clk,
    input  logic          RST,
    bcd_count_ctrl_if.slave ctl
);

    state_t           state;
    logic             busy;
    logic             done;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_d;

    logic             tick;
    logic             pre_run;
    logic             pre_clr;
    logic             term_hit;
    logic [CNT_W-1:0] load_d;

    // Prescaler only advances on RUN cycles that are not being left; it restarts from any idle/done cycle.
    assign pre_run = (state == RUN) && !ctl.Stop && !ctl.Pause;
    assign pre_clr = (state == IDLE) || (state == DONE) || ctl.Stop;

    assign term_hit = (int'(ctl.Target) < MODULUS)
                   && (ctl.Cnt_Q == term_value(ctl.Target, MODULUS));
    assign load_d   = (int'(ctl.Load_Val) >= MODULUS) ? '0 : ctl.Load_Val;

    tick_prescaler #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_FAST (DIV_FAST)
    ) u_prescaler (
        .clk  (Clk),
        .rst  (RST),
        .run  (pre_run),
        .clr  (pre_clr),
        .mode (ctl.Mode),
        .tick (tick)
    );

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_load <= 1'b0;
            cnt_d    <= '0;
        end else begin
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_load <= 1'b0;
            cnt_d    <= '0;
            unique case (state)
                IDLE: begin
                    if (!ctl.Stop) begin
                        if (ctl.Start) begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            cnt_clr <= 1'b1;
                        end else if (ctl.Load) begin
                            cnt_load <= 1'b1;
                            cnt_d    <= load_d;
                        end
                    end
                end
                RUN: begin
                    if (ctl.Stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (ctl.Pause) begin
                        state <= PAUSE;
                    end else if (tick) begin
                        cnt_en <= 1'b1;
                        if (term_hit) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (ctl.Stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (ctl.Pause) begin
                        state <= RUN;
                    end else if (ctl.Step) begin
                        cnt_en <= 1'b1;
                        if (term_hit) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ctl.Stop) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (ctl.Start || ctl.Auto_Reload) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        cnt_clr <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign ctl.Cnt_En   = cnt_en;
    assign ctl.Cnt_Clr  = cnt_clr;
    assign ctl.Cnt_Load = cnt_load;
    assign ctl.Cnt_D    = cnt_d;
    assign ctl.Busy     = busy;
    assign ctl.Done     = done;
    assign ctl.State    = state;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: directed scenarios then random panel activity against a rule-level model.
// A mod-10 counter in the bench closes the Cnt_Q feedback loop.
module tb_bcd_count_ctrl;

    localparam int MOD = 10;
    localparam int DS  = 4;
    localparam int DF  = 2;

    logic Clk = 1'b0;
    logic RST;
    always #5 Clk = ~Clk;

    bcd_count_ctrl_if bus();

    bcd_count_ctrl #(
        .MODULUS  (MOD),
        .DIV_SLOW (DS),
        .DIV_FAST (DF)
    ) dut (
        .Clk (Clk),
        .RST (RST),
        .ctl (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int cnt         = 0;

    // reference model: state number per the published encoding, prescaler position and period in cycles
    int m_state, m_pre, m_period;
    bit e_en, e_clr, e_load;
    int e_d;

    logic       d_en, d_clr, d_load, d_busy, d_done;
    logic [3:0] d_d;
    logic [1:0] d_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        d_en    = bus.Cnt_En;
        d_clr   = bus.Cnt_Clr;
        d_load  = bus.Cnt_Load;
        d_d     = bus.Cnt_D;
        d_busy  = bus.Busy;
        d_done  = bus.Done;
        d_state = bus.State;
    endtask

    function automatic logic [10:0] pack_obs();
        return {d_en, d_clr, d_load, d_d, d_busy, d_done, d_state};
    endfunction

    function automatic logic [10:0] pack_exp();
        return {e_en, e_clr, e_load, 4'(e_d), (m_state == 1 || m_state == 2), (m_state == 3), 2'(m_state)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_pre = 0; m_period = DS;
        e_en = 0; e_clr = 0; e_load = 0; e_d = 0;
    endtask

    task automatic model_step();
        int  old_state, div_now, tval;
        bit  hit, fire;
        old_state = m_state;
        div_now   = bus.Mode ? DF : DS;
        tval      = (bus.Target == 0) ? MOD - 1 : int'(bus.Target) - 1;
        hit       = (int'(bus.Target) < MOD) && (cnt == tval);
        fire      = 0;
        e_en = 0; e_clr = 0; e_load = 0; e_d = 0;
        case (m_state)
            0: begin
                if (!bus.Stop && bus.Start) begin
                    e_clr = 1; m_state = 1;
                end else if (!bus.Stop && bus.Load) begin
                    e_load = 1;
                    e_d    = (int'(bus.Load_Val) >= MOD) ? 0 : int'(bus.Load_Val);
                end
            end
            1: begin
                if (bus.Stop) m_state = 0;
                else if (bus.Pause) m_state = 2;
                else if (m_pre == m_period - 1 || m_pre >= div_now) begin
                    fire = 1; m_pre = 0; m_period = div_now;
                end else m_pre++;
            end
            2: begin
                if (bus.Stop) m_state = 0;
                else if (bus.Pause) m_state = 1;
                else if (bus.Step) fire = 1;
            end
            default: begin
                if (bus.Stop) m_state = 0;
                else if (bus.Start || bus.Auto_Reload) begin
                    e_clr = 1; m_state = 1;
                end
            end
        endcase
        if (fire) begin
            e_en = 1;
            if (hit) m_state = 3;
        end
        if (old_state == 0 || old_state == 3 || bus.Stop) begin
            m_pre = 0; m_period = div_now;
        end
    endtask

    task automatic clk_cycle();
        @(posedge Clk);
        model_step();
        if (d_clr) cnt = 0;
        else if (d_load) cnt = int'(d_d);
        else if (d_en) cnt = (cnt + 1) % MOD;
        #1 bus.Cnt_Q = 4'(cnt);
        @(negedge Clk);
        sample();
        cyc++;
        check($sformatf("outs@%0d", cyc), 32'(pack_obs()), 32'(pack_exp()));
        bus.Stop = 0; bus.Pause = 0; bus.Step = 0; bus.Load = 0;
    endtask

    initial begin
        int n_en, n_clr, n_done, last_en;
        logic prev_done;

        RST = 1'b1;
        bus.Start = 0; bus.Stop = 0; bus.Pause = 0; bus.Step = 0; bus.Load = 0;
        bus.Load_Val = 0; bus.Mode = 0; bus.Target = 4'd15; bus.Auto_Reload = 0; bus.Cnt_Q = 0;
        model_reset();
        repeat (2) @(negedge Clk);
        sample();
        check("reset_outs", 32'(pack_obs()), 32'h0);
        RST = 1'b0;

        // 1: free-run, enable every DS cycles, single clear
        bus.Start = 1; n_en = 0; n_clr = 0; last_en = -1;
        for (int i = 0; i < 45; i++) begin
            clk_cycle();
            if (d_clr) n_clr++;
            if (d_en) begin
                if (last_en >= 0) check("s1_en_gap", cyc - last_en, DS);
                last_en = cyc; n_en++;
            end
        end
        check("s1_clr_once", n_clr, 1);
        check("s1_en_count", n_en, 11);
        bus.Start = 0; bus.Stop = 1; clk_cycle();

        // 2: target 3 without reload stops in DONE
        bus.Target = 4'd3; bus.Start = 1; clk_cycle(); bus.Start = 0;
        n_en = 0;
        for (int i = 0; i < 60 && !d_done; i++) begin
            clk_cycle();
            if (d_en) n_en++;
        end
        check("s2_done", d_done, 1);
        check("s2_state", d_state, 3);
        check("s2_en_to_done", n_en, 3);
        clk_cycle();
        check("s2_cnt", cnt, 3);
        n_en = 0;
        repeat (12) begin clk_cycle(); n_en += int'(d_en); end
        check("s2_no_more_en", n_en, 0);
        bus.Stop = 1; clk_cycle();

        // 3: pause at prescaler 2, two steps, resume
        bus.Target = 4'd15; bus.Start = 1; clk_cycle(); bus.Start = 0;
        for (int i = 0; i < 40 && !d_en; i++) clk_cycle();
        check("s3_first_en", d_en, 1);
        repeat (2) clk_cycle();
        bus.Pause = 1; clk_cycle();
        check("s3_paused", d_state, 2);
        n_en = 0;
        repeat (8) begin clk_cycle(); n_en += int'(d_en); end
        check("s3_no_en_paused", n_en, 0);
        bus.Step = 1; clk_cycle();
        check("s3_step1", d_en, 1);
        repeat (3) clk_cycle();
        bus.Step = 1; clk_cycle();
        check("s3_step2", d_en, 1);
        clk_cycle();
        bus.Pause = 1; clk_cycle();
        check("s3_resume_state", d_state, 1);
        check("s3_resume_en0", d_en, 0);
        clk_cycle(); check("s3_resume_en1", d_en, 0);
        clk_cycle(); check("s3_resume_en2", d_en, 1);
        bus.Stop = 1; clk_cycle();

        // 4: preset in IDLE, out-of-range preset, preset ignored in RUN
        bus.Load = 1; bus.Load_Val = 4'd7; clk_cycle();
        check("s4_load7", {d_load, d_d}, 5'h17);
        bus.Load = 1; bus.Load_Val = 4'd12; clk_cycle();
        check("s4_load12", {d_load, d_d}, 5'h10);
        clk_cycle();
        bus.Start = 1; clk_cycle(); bus.Start = 0;
        repeat (3) clk_cycle();
        bus.Load = 1; bus.Load_Val = 4'd5; clk_cycle();
        check("s4_load_in_run", d_load, 0);
        bus.Stop = 1; clk_cycle();

        // 5: target 2 with auto-reload restarts every 9 cycles
        bus.Target = 4'd2; bus.Auto_Reload = 1; bus.Start = 1; clk_cycle(); bus.Start = 0;
        n_done = 0; prev_done = 0;
        for (int i = 0; i < 59; i++) begin
            clk_cycle();
            if (d_done) begin
                n_done++;
                check("s5_done_one_cycle", prev_done, 0);
                check("s5_cnt_at_done", cnt, 1);
            end
            prev_done = d_done;
        end
        check("s5_done_count", n_done, 6);
        bus.Auto_Reload = 0; bus.Stop = 1; clk_cycle();

        // 6: mode switch with overrun prescaler, stop+start, async reset
        bus.Target = 4'd15; bus.Mode = 0; bus.Start = 1; clk_cycle(); bus.Start = 0;
        for (int i = 0; i < 40 && !d_en; i++) clk_cycle();
        check("s6_first_en", d_en, 1);
        repeat (2) clk_cycle();
        bus.Mode = 1; clk_cycle();
        check("s6_mode_wrap", d_en, 1);
        clk_cycle(); check("s6_fast_gap0", d_en, 0);
        clk_cycle(); check("s6_fast_gap1", d_en, 1);
        bus.Stop = 1; bus.Start = 1; clk_cycle();
        check("s6_stop_start_state", d_state, 0);
        check("s6_stop_start_clr", d_clr, 0);
        clk_cycle();
        check("s6_restart", d_state, 1);
        bus.Start = 0;
        repeat (5) clk_cycle();
        #2 RST = 1'b1;
        #1 sample();
        check("s6_async_rst", 32'(pack_obs()), 32'h0);
        model_reset();
        cnt = 0; bus.Cnt_Q = 0; bus.Mode = 0;
        #1 RST = 1'b0;
        repeat (3) clk_cycle();

        // random panel activity
        for (int i = 0; i < 1500; i++) begin
            bus.Start    = ($urandom_range(0, 24) == 0);
            bus.Stop     = ($urandom_range(0, 79) == 0);
            bus.Pause    = ($urandom_range(0, 19) == 0);
            bus.Step     = ($urandom_range(0, 7) == 0);
            bus.Load     = ($urandom_range(0, 11) == 0);
            bus.Load_Val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) bus.Mode = ~bus.Mode;
            if ($urandom_range(0, 49) == 0) bus.Target = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) bus.Auto_Reload = ~bus.Auto_Reload;
            clk_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
